// File: rtl/opcode_assembler_if.sv
// Handshake bundle between the host word stream, the opcode assembler and
// the rasterizer front end.
//   word_in/word_valid/word_ready       : 32-bit host command words in
//   opcode/opcode_valid/opcode_ready    : 96-bit assembled opcodes out
// The slave modport is the assembler's view; master is the host/consumer side.
interface opcode_assembler_if;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [95:0] opcode;
    logic        opcode_valid;
    logic        opcode_ready;

    modport master (
        output word_in,
        output word_valid,
        output opcode_ready,
        input  word_ready,
        input  opcode,
        input  opcode_valid
    );

    modport slave (
        input  word_in,
        input  word_valid,
        input  opcode_ready,
        output word_ready,
        output opcode,
        output opcode_valid
    );
endinterface

// File: rtl/opcode_assembler.sv
// Host-side opcode assembler for the 2D GPU command path. Packs three 32-bit
// host command words into one 96-bit opcode and buffers completed opcodes in
// a DEPTH-entry FIFO for the rasterizer front end.
//
// Ports:
//   clk        : system clock, rising edge
//   n_rst      : asynchronous active-low reset
//   flush      : synchronous clear of FIFO and any partial opcode
//   bus        : word_in/word_valid/word_ready in, opcode/opcode_valid/opcode_ready out
//   count      : number of opcodes held in the FIFO
//   assembling : a partial opcode (word0 or word0+word1) is held
//
// Phase FSM:
//   state | meaning
//   P0    | waiting for word0 (shape/color/opdata[75:64])
//   P1    | word0 held, waiting for word1
//   P2    | word0 and word1 held, waiting for word2; stalls while FIFO full
module opcode_assembler #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         flush,
    opcode_assembler_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         assembling
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2
    } phase_t;

    phase_t          phase_q;
    phase_t          phase_d;

    logic [31:0]     hold0_q;
    logic [31:0]     hold1_q;
    logic            load0;
    logic            load1;

    logic [95:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic            word_ready;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // Phase FSM: state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase_q <= P0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase FSM: next state and per-word strobes. word_ready looks only at
    // phase and count, so a pop in the same cycle never lets a full FIFO
    // take word2.
    always_comb begin
        phase_d    = phase_q;
        word_ready = 1'b1;
        load0      = 1'b0;
        load1      = 1'b0;
        push       = 1'b0;

        case (phase_q)
            P0: begin
                if (bus.word_valid) begin
                    load0   = 1'b1;
                    phase_d = P1;
                end
            end
            P1: begin
                if (bus.word_valid) begin
                    load1   = 1'b1;
                    phase_d = P2;
                end
            end
            P2: begin
                word_ready = !fifo_full;
                if (bus.word_valid && !fifo_full) begin
                    push    = 1'b1;
                    phase_d = P0;
                end
            end
            default: begin
                phase_d = P0;
            end
        endcase

        // Flush wins over anything accepted this cycle.
        if (flush) begin
            phase_d = P0;
            load0   = 1'b0;
            load1   = 1'b0;
            push    = 1'b0;
        end
    end

    assign pop = !fifo_empty && bus.opcode_ready && !flush;

    // Partial-opcode hold registers. Flush leaves them alone; the next
    // word0/word1 overwrite them before they are ever used.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold0_q <= '0;
            hold1_q <= '0;
        end else begin
            if (load0) begin
                hold0_q <= bus.word_in;
            end
            if (load1) begin
                hold1_q <= bus.word_in;
            end
        end
    end

    // FIFO storage carries no reset; contents are only visible while count
    // says the entry is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {hold0_q, hold1_q, bus.word_in};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.word_ready   = word_ready;
    assign bus.opcode_valid = !fifo_empty;
    assign bus.opcode       = fifo_empty ? 96'd0 : mem[rd_ptr_q];
    assign count            = count_q;
    assign assembling       = (phase_q != P0);

endmodule
